boot_loader: RTL and testbench
==============================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256: instruction-memory words available for a program.
REQ-002 SHALL have parameter BASE_ADDR, default 16'h0000: load address of the first program word.
REQ-003 SHALL have parameter RELEASE_CYCLES, default 2: cycles cpu_reset stays high after the last write.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port pc_reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port start, input, 1: one-cycle request to begin a program load.
REQ-007 SHALL have port word_valid, input, 1: word_data and word_last are valid.
REQ-008 SHALL have port word_data, input, 16: instruction word.
REQ-009 SHALL have port word_last, input, 1: the current word is the final program word.
REQ-010 SHALL have port word_ready, output, 1: loader accepts a word this cycle.
REQ-011 SHALL have port imem_we, output, 1: instruction-memory write strobe (drives load_instruction).
REQ-012 SHALL have port imem_addr, output, 16: write address (drives load_address).
REQ-013 SHALL have port imem_data, output, 16: write data (drives instruction_in).
REQ-014 SHALL have port cpu_reset, output, 1: active-high hold of the CPU PC/register reset.
REQ-015 SHALL have port busy, output, 1: high in LOAD or DRAIN.
REQ-016 SHALL have port done, output, 1: high in RUN.
REQ-017 SHALL have port error, output, 1: high in ERROR.
REQ-018 SHALL have port word_count, output, 16: words written in the current or most recent load.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, DRAIN, RUN, ERROR; all outputs registered except word_ready, which is decoded from state.
REQ-020 IDLE SHALL hold cpu_reset=1 and word_ready=0; start=1 SHALL move to LOAD, clear word_count and set the write pointer to BASE_ADDR.
REQ-021 LOAD SHALL drive word_ready=1; a handshake is word_valid & word_ready in the same cycle.
REQ-022 Each handshake SHALL produce imem_we=1 for exactly one cycle, the cycle after the handshake, with imem_addr=pointer and imem_data=word_data.
REQ-023 Each handshake SHALL increment the pointer and word_count by 1; back-to-back handshakes SHALL give consecutive write cycles with no bubbles.
REQ-024 A handshake with word_last=1 SHALL move LOAD to DRAIN; that word is written normally.
REQ-025 A handshake when word_count equals MEM_DEPTH and word_last=0 SHALL NOT write and SHALL move to ERROR.
REQ-026 A last word accepted at word_count = MEM_DEPTH-1 SHALL be legal and go to DRAIN.
REQ-027 DRAIN SHALL hold cpu_reset=1 and word_ready=0 for RELEASE_CYCLES cycles after the final imem_we pulse, then enter RUN.
REQ-028 RUN SHALL drive cpu_reset=0 and done=1; start=1 SHALL re-enter LOAD with cpu_reset=1 from the next cycle.
REQ-029 ERROR SHALL hold cpu_reset=1, word_ready=0 and error=1; start=1 SHALL clear error and re-enter LOAD.
REQ-030 start SHALL be ignored in LOAD and DRAIN.
REQ-031 word_count SHALL hold its value in RUN and ERROR until the next start.
REQ-032 imem_addr SHALL be the 16-bit sum BASE_ADDR+word_count, modulo 2^16.
REQ-033 imem_addr and imem_data SHALL hold their last values when imem_we=0.

Reset
REQ-034 pc_reset_n low SHALL immediately force state IDLE, cpu_reset=1, imem_we=0, imem_addr=0, imem_data=0, word_count=0, busy=0, done=0, error=0, including mid-LOAD or mid-DRAIN.
REQ-035 After pc_reset_n deasserts, the first start SHALL be accepted no earlier than the first rising edge.

Structure
REQ-036 The state encoding and the defaults of MEM_DEPTH, BASE_ADDR and RELEASE_CYCLES SHALL live in a shared package with the CPU opcode constants.
REQ-037 The DRAIN hold SHALL be a sub-module named release_timer: a down-counter with a load input and a zero flag.

Verification
REQ-038 Reset, start, 3 words (0x1111, 0x2222, 0x3333 with last) at back-to-back valid -> writes to addresses 0,1,2 on consecutive cycles; cpu_reset falls 2 cycles after the third write; done=1; word_count=3.
REQ-039 Same load with word_valid toggled every other cycle -> same writes and addresses, no duplicate or missing imem_we.
REQ-040 MEM_DEPTH=4, feed 5 words with no last -> 4 writes to addresses 0-3, 5th not written, error=1, cpu_reset stays 1; a new start clears error.
REQ-041 MEM_DEPTH=4, 4 words with last on the 4th -> DRAIN then RUN, error=0.
REQ-042 pc_reset_n pulsed low after the 2nd word -> all outputs at reset values asynchronously; a fresh start reloads from BASE_ADDR.
REQ-043 In RUN, start -> cpu_reset=1 the next cycle, word_count=0, reload of 1 word 0xABCD with last at address 0 -> RUN again.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: loader state encoding, default geometry and the CPU opcode constants shared with the core.
package boot_loader_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_RUN, S_ERROR} state_t;
  localparam int unsigned MEM_DEPTH_DEF = 256;
  localparam logic [15:0] BASE_ADDR_DEF = 16'h0000;
  localparam int unsigned RELEASE_CYCLES_DEF = 2;
  localparam int unsigned TIMER_W = 8;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR = 4'h4;
  localparam logic [3:0] OP_LOAD = 4'h5;
  localparam logic [3:0] OP_STORE = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_BEQ = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;
endpackage

// File: rtl/boot_loader_release_timer.sv
// release_timer: loadable down-counter that stops at zero and flags it.
module release_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= value;
    else if (en && !zero) cnt <= cnt - W'(1);
endmodule

// File: rtl/boot_loader.sv
// boot_loader: streams a program into instruction memory while holding the CPU in reset, then releases it.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned MEM_DEPTH      = MEM_DEPTH_DEF,
  parameter logic [15:0] BASE_ADDR      = BASE_ADDR_DEF,
  parameter int unsigned RELEASE_CYCLES = RELEASE_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        pc_reset_n,
  input  logic        start,
  input  logic        word_valid,
  input  logic [15:0] word_data,
  input  logic        word_last,
  output logic        word_ready,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_data,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);
  state_t state;
  logic hs, full, rel_zero;
  assign word_ready = state == S_LOAD;
  assign hs = word_valid & word_ready;
  assign full = 32'(word_count) >= MEM_DEPTH;
  // the timer is armed on the final handshake so it counts from the write cycle onward
  release_timer #(.W(TIMER_W)) u_release_timer (
    .clk  (clk),
    .rst_n(pc_reset_n),
    .load (hs & word_last & !full),
    .en   (state == S_DRAIN),
    .value(TIMER_W'(RELEASE_CYCLES)),
    .zero (rel_zero)
  );
  always_ff @(posedge clk or negedge pc_reset_n)
    if (!pc_reset_n) begin
      state      <= S_IDLE;
      cpu_reset  <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_data  <= '0;
      word_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_RUN, S_ERROR: if (start) begin
          state      <= S_LOAD;
          cpu_reset  <= 1'b1;
          busy       <= 1'b1;
          done       <= 1'b0;
          error      <= 1'b0;
          word_count <= '0;
        end
        S_LOAD: if (hs) begin
          if (full) begin
            state <= S_ERROR;
            busy  <= 1'b0;
            error <= 1'b1;
          end else begin
            imem_we    <= 1'b1;
            imem_addr  <= BASE_ADDR + word_count;
            imem_data  <= word_data;
            word_count <= word_count + 16'd1;
            if (word_last) state <= S_DRAIN;
          end
        end
        S_DRAIN: if (rel_zero) begin
          state     <= S_RUN;
          cpu_reset <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed vector table against a default loader and a 4-word loader sharing one stimulus stream.
module tb_boot_loader;
  logic clk = 1'b0, pc_reset_n = 1'b0, start = 1'b0, word_valid = 1'b0, word_last = 1'b0;
  logic [15:0] word_data = '0;
  logic [1:0] ready, we, cpu, busy, done, err;
  logic [15:0] addr[2], wdata[2], cnt[2];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  boot_loader dut (
    .clk(clk), .pc_reset_n(pc_reset_n), .start(start), .word_valid(word_valid),
    .word_data(word_data), .word_last(word_last), .word_ready(ready[0]), .imem_we(we[0]),
    .imem_addr(addr[0]), .imem_data(wdata[0]), .cpu_reset(cpu[0]), .busy(busy[0]),
    .done(done[0]), .error(err[0]), .word_count(cnt[0])
  );
  boot_loader #(.MEM_DEPTH(4)) dut4 (
    .clk(clk), .pc_reset_n(pc_reset_n), .start(start), .word_valid(word_valid),
    .word_data(word_data), .word_last(word_last), .word_ready(ready[1]), .imem_we(we[1]),
    .imem_addr(addr[1]), .imem_data(wdata[1]), .cpu_reset(cpu[1]), .busy(busy[1]),
    .done(done[1]), .error(err[1]), .word_count(cnt[1])
  );
  typedef struct packed {
    logic        sel;
    logic [2:0]  in3;
    logic [15:0] data;
    logic [53:0] exp;
  } vec_t;
  vec_t q[$];
  function automatic vec_t mk(input logic sel, input logic [2:0] in3, input logic [15:0] data,
                              input logic [5:0] flags, input logic [15:0] a, input logic [15:0] d,
                              input logic [15:0] c);
    return '{sel: sel, in3: in3, data: data, exp: {flags, a, d, c}};
  endfunction
  function automatic logic [53:0] outs(input int s);
    return {ready[s], we[s], cpu[s], busy[s], done[s], err[s], addr[s], wdata[s], cnt[s]};
  endfunction
  task automatic check(input string name, input logic [53:0] got, input logic [53:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got rdy/we/cpu/busy/done/err=%b addr=%h data=%h cnt=%h, expected %b addr=%h data=%h cnt=%h",
               name, got[53:48], got[47:32], got[31:16], got[15:0], exp[53:48], exp[47:32], exp[31:16], exp[15:0]);
    end
  endtask
  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      {start, word_valid, word_last} = q[i].in3;
      word_data = q[i].data;
      @(posedge clk);
      #1;
      check($sformatf("row%0d", i), outs(int'(q[i].sel)), q[i].exp);
    end
    {start, word_valid, word_last} = 3'b000;
    word_data = '0;
  endtask
  int split;
  initial begin
    // flags are {word_ready, imem_we, cpu_reset, busy, done, error}; in3 is {start, valid, last}
    q.push_back(mk(0, 3'b000, 16'h0000, 6'b001000, 16'h0, 16'h0000, 16'd0));
    q.push_back(mk(0, 3'b100, 16'h0000, 6'b101100, 16'h0, 16'h0000, 16'd0));
    q.push_back(mk(0, 3'b010, 16'h1111, 6'b111100, 16'h0, 16'h1111, 16'd1));
    q.push_back(mk(0, 3'b010, 16'h2222, 6'b111100, 16'h1, 16'h2222, 16'd2));
    q.push_back(mk(0, 3'b011, 16'h3333, 6'b011100, 16'h2, 16'h3333, 16'd3));
    q.push_back(mk(0, 3'b000, 16'h0000, 6'b001100, 16'h2, 16'h3333, 16'd3));
    q.push_back(mk(0, 3'b000, 16'h0000, 6'b001100, 16'h2, 16'h3333, 16'd3));
    q.push_back(mk(0, 3'b000, 16'h0000, 6'b000010, 16'h2, 16'h3333, 16'd3));
    q.push_back(mk(0, 3'b100, 16'h0000, 6'b101100, 16'h2, 16'h3333, 16'd0));
    q.push_back(mk(0, 3'b000, 16'h0000, 6'b101100, 16'h2, 16'h3333, 16'd0));
    q.push_back(mk(0, 3'b010, 16'h1111, 6'b111100, 16'h0, 16'h1111, 16'd1));
    q.push_back(mk(0, 3'b100, 16'h9999, 6'b101100, 16'h0, 16'h1111, 16'd1));
    q.push_back(mk(0, 3'b010, 16'h2222, 6'b111100, 16'h1, 16'h2222, 16'd2));
    q.push_back(mk(0, 3'b000, 16'h0000, 6'b101100, 16'h1, 16'h2222, 16'd2));
    q.push_back(mk(0, 3'b011, 16'h3333, 6'b011100, 16'h2, 16'h3333, 16'd3));
    q.push_back(mk(0, 3'b100, 16'h0000, 6'b001100, 16'h2, 16'h3333, 16'd3));
    q.push_back(mk(0, 3'b000, 16'h0000, 6'b001100, 16'h2, 16'h3333, 16'd3));
    q.push_back(mk(0, 3'b000, 16'h0000, 6'b000010, 16'h2, 16'h3333, 16'd3));
    q.push_back(mk(0, 3'b100, 16'h0000, 6'b101100, 16'h2, 16'h3333, 16'd0));
    q.push_back(mk(0, 3'b011, 16'hABCD, 6'b011100, 16'h0, 16'hABCD, 16'd1));
    q.push_back(mk(0, 3'b010, 16'hFFFF, 6'b001100, 16'h0, 16'hABCD, 16'd1));
    q.push_back(mk(0, 3'b000, 16'h0000, 6'b001100, 16'h0, 16'hABCD, 16'd1));
    q.push_back(mk(0, 3'b000, 16'h0000, 6'b000010, 16'h0, 16'hABCD, 16'd1));
    q.push_back(mk(1, 3'b100, 16'h0000, 6'b101100, 16'h0, 16'hABCD, 16'd0));
    q.push_back(mk(1, 3'b010, 16'h0001, 6'b111100, 16'h0, 16'h0001, 16'd1));
    q.push_back(mk(1, 3'b010, 16'h0002, 6'b111100, 16'h1, 16'h0002, 16'd2));
    q.push_back(mk(1, 3'b010, 16'h0003, 6'b111100, 16'h2, 16'h0003, 16'd3));
    q.push_back(mk(1, 3'b010, 16'h0004, 6'b111100, 16'h3, 16'h0004, 16'd4));
    q.push_back(mk(1, 3'b010, 16'h0005, 6'b001001, 16'h3, 16'h0004, 16'd4));
    q.push_back(mk(1, 3'b000, 16'h0000, 6'b001001, 16'h3, 16'h0004, 16'd4));
    q.push_back(mk(1, 3'b100, 16'h0000, 6'b101100, 16'h3, 16'h0004, 16'd0));
    q.push_back(mk(1, 3'b010, 16'h000A, 6'b111100, 16'h0, 16'h000A, 16'd1));
    q.push_back(mk(1, 3'b010, 16'h000B, 6'b111100, 16'h1, 16'h000B, 16'd2));
    q.push_back(mk(1, 3'b010, 16'h000C, 6'b111100, 16'h2, 16'h000C, 16'd3));
    q.push_back(mk(1, 3'b011, 16'h000D, 6'b011100, 16'h3, 16'h000D, 16'd4));
    q.push_back(mk(1, 3'b000, 16'h0000, 6'b001100, 16'h3, 16'h000D, 16'd4));
    q.push_back(mk(1, 3'b000, 16'h0000, 6'b001100, 16'h3, 16'h000D, 16'd4));
    q.push_back(mk(1, 3'b000, 16'h0000, 6'b000010, 16'h3, 16'h000D, 16'd4));
    q.push_back(mk(0, 3'b000, 16'h0000, 6'b000010, 16'h8, 16'h000D, 16'd9));
    q.push_back(mk(0, 3'b100, 16'h0000, 6'b101100, 16'h8, 16'h000D, 16'd0));
    q.push_back(mk(0, 3'b010, 16'h1234, 6'b111100, 16'h0, 16'h1234, 16'd1));
    q.push_back(mk(0, 3'b010, 16'h5678, 6'b111100, 16'h1, 16'h5678, 16'd2));
    split = q.size();
    q.push_back(mk(0, 3'b100, 16'h0000, 6'b101100, 16'h0, 16'h0000, 16'd0));
    q.push_back(mk(0, 3'b011, 16'h5555, 6'b011100, 16'h0, 16'h5555, 16'd1));
    q.push_back(mk(0, 3'b000, 16'h0000, 6'b001100, 16'h0, 16'h5555, 16'd1));
    q.push_back(mk(0, 3'b000, 16'h0000, 6'b001100, 16'h0, 16'h5555, 16'd1));
    q.push_back(mk(0, 3'b000, 16'h0000, 6'b000010, 16'h0, 16'h5555, 16'd1));
    repeat (3) @(posedge clk);
    #1;
    check("reset_dut", outs(0), {6'b001000, 48'h0});
    check("reset_dut4", outs(1), {6'b001000, 48'h0});
    pc_reset_n = 1'b1;
    run(0, split);
    #2 pc_reset_n = 1'b0;
    #1;
    check("async_reset_dut", outs(0), {6'b001000, 48'h0});
    check("async_reset_dut4", outs(1), {6'b001000, 48'h0});
    start = 1'b1;
    @(posedge clk);
    #1;
    check("reset_held_start", outs(0), {6'b001000, 48'h0});
    start = 1'b0;
    pc_reset_n = 1'b1;
    run(split, q.size());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
